// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse train sequencer: default widths and FSM state codes.
package pulse_pkg;

   localparam int unsigned RAM_WIDTH_DEF = 32;
   localparam int unsigned CNT_W_DEF     = 16;

   typedef logic [2:0] pulse_state_t;

   localparam pulse_state_t IDLE  = 3'd0;
   localparam pulse_state_t DELAY = 3'd1;
   localparam pulse_state_t FIRE  = 3'd2;
   localparam pulse_state_t RUN   = 3'd3;
   localparam pulse_state_t DONE  = 3'd4;
   localparam pulse_state_t ABORT = 3'd5;

endpackage

// File: rtl/pulse_train_ctrl_if.sv
// Control, configuration, status and sigpulse-side signals of one pulse train channel.
interface pulse_train_ctrl_if
   import pulse_pkg::*;
#(
   parameter int unsigned _RAM_WIDTH = RAM_WIDTH_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
);

   logic                  start;
   logic                  stop;
   logic [_RAM_WIDTH-1:0] cfg_delay;
   logic [_RAM_WIDTH-1:0] cfg_width;
   logic [_RAM_WIDTH-1:0] cfg_period;
   logic [CNT_W-1:0]      cfg_count;
   logic                  sp_valid;
   logic                  sp_en;
   logic [_RAM_WIDTH-1:0] sp_width;
   logic                  sp_dis;
   logic                  busy;
   logic                  done;
   logic                  aborted;
   logic                  err_cfg;
   logic                  err_miss;
   logic [CNT_W-1:0]      pulse_idx;

   // Sequencer side
   modport slave (
      input  start, stop, cfg_delay, cfg_width, cfg_period, cfg_count, sp_valid,
      output sp_en, sp_width, sp_dis, busy, done, aborted, err_cfg, err_miss, pulse_idx
   );

   // Host / sigpulse side
   modport master (
      output start, stop, cfg_delay, cfg_width, cfg_period, cfg_count, sp_valid,
      input  sp_en, sp_width, sp_dis, busy, done, aborted, err_cfg, err_miss, pulse_idx
   );

endinterface

// File: rtl/pulse_cfg_check.sv
// Combinational validation of a requested pulse train configuration.
module pulse_cfg_check #(
   parameter int unsigned _RAM_WIDTH = 32,
   parameter int unsigned CNT_W      = 16
) (
   input  logic [_RAM_WIDTH-1:0] cfg_width,
   input  logic [_RAM_WIDTH-1:0] cfg_period,
   input  logic [CNT_W-1:0]      cfg_count,
   output logic                  cfg_ok
);

   // Period must strictly exceed width so each pulse finishes inside its own slot
   always_comb begin
      cfg_ok = (cfg_width != '0) && (cfg_count != '0) && (cfg_period > cfg_width);
   end

endmodule

// File: rtl/pulse_train_ctrl.sv
// Sequencer for one sigpulse channel: delay, then a train of fixed-period pulses,
// with completion supervision via sp_valid and abort on stop or missing pulse.
module pulse_train_ctrl
   import pulse_pkg::*;
#(
   parameter int unsigned _RAM_WIDTH = RAM_WIDTH_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input logic               io_clk,
   input logic               io_rst,
   pulse_train_ctrl_if.slave bus
);

   localparam logic [_RAM_WIDTH-1:0] R_ONE = _RAM_WIDTH'(1);
   localparam logic [_RAM_WIDTH-1:0] R_TWO = _RAM_WIDTH'(2);
   localparam logic [CNT_W-1:0]      C_ONE = CNT_W'(1);

   pulse_state_t          state_q, state_d;
   logic [_RAM_WIDTH-1:0] dcnt_q, dcnt_d;
   logic [_RAM_WIDTH-1:0] pcnt_q, pcnt_d;
   logic [_RAM_WIDTH-1:0] width_q, width_d;
   logic [_RAM_WIDTH-1:0] period_q, period_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_W-1:0]      idx_q, idx_d;
   logic                  seen_q, seen_d;
   logic                  miss_q, miss_d;
   logic                  err_cfg_q, err_cfg_d;
   logic                  cfg_ok;

   pulse_cfg_check #(
      ._RAM_WIDTH(_RAM_WIDTH),
      .CNT_W     (CNT_W)
   ) u_cfg_check (
      .cfg_width (bus.cfg_width),
      .cfg_period(bus.cfg_period),
      .cfg_count (bus.cfg_count),
      .cfg_ok    (cfg_ok)
   );

   // Next-state logic for the train FSM, counters and latched configuration
   always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      pcnt_d    = pcnt_q;
      width_d   = width_q;
      period_d  = period_q;
      count_d   = count_q;
      idx_d     = idx_q;
      seen_d    = seen_q;
      miss_d    = miss_q;
      err_cfg_d = 1'b0;

      case (state_q)
         IDLE: begin
            // stop wins over a same-cycle start
            if (bus.start && !bus.stop) begin
               if (cfg_ok) begin
                  width_d  = bus.cfg_width;
                  period_d = bus.cfg_period;
                  count_d  = bus.cfg_count;
                  dcnt_d   = bus.cfg_delay;
                  idx_d    = '0;
                  miss_d   = 1'b0;
                  state_d  = DELAY;
               end else begin
                  err_cfg_d = 1'b1;
               end
            end
         end
         DELAY: begin
            if (dcnt_q != '0) begin
               dcnt_d = dcnt_q - R_ONE;
            end else begin
               state_d = FIRE;
            end
         end
         FIRE: begin
            // FIRE plus the RUN cycles that follow span exactly one period
            pcnt_d  = period_q - R_TWO;
            seen_d  = 1'b0;
            state_d = RUN;
         end
         RUN: begin
            if (bus.sp_valid) begin
               seen_d = 1'b1;
            end
            if (pcnt_q != '0) begin
               pcnt_d = pcnt_q - R_ONE;
            end else if (!seen_q && !bus.sp_valid) begin
               miss_d  = 1'b1;
               state_d = ABORT;
            end else if (idx_q == count_q - C_ONE) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + C_ONE;
               state_d = FIRE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         ABORT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A stop overrides whatever the state above decided, including a miss
      if (bus.stop && (state_q != IDLE) && (state_q != DONE)) begin
         state_d = ABORT;
         idx_d   = idx_q;
         miss_d  = miss_q;
      end
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         state_q   <= IDLE;
         dcnt_q    <= '0;
         pcnt_q    <= '0;
         width_q   <= '0;
         period_q  <= '0;
         count_q   <= '0;
         idx_q     <= '0;
         seen_q    <= 1'b0;
         miss_q    <= 1'b0;
         err_cfg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dcnt_q    <= dcnt_d;
         pcnt_q    <= pcnt_d;
         width_q   <= width_d;
         period_q  <= period_d;
         count_q   <= count_d;
         idx_q     <= idx_d;
         seen_q    <= seen_d;
         miss_q    <= miss_d;
         err_cfg_q <= err_cfg_d;
      end
   end

   // Outputs decode directly from registered state so reset clears them at once
   always_comb begin
      bus.sp_en     = (state_q == FIRE);
      bus.sp_dis    = (state_q == ABORT);
      bus.aborted   = (state_q == ABORT);
      bus.done      = (state_q == DONE);
      bus.busy      = (state_q != IDLE);
      bus.sp_width  = width_q;
      bus.err_cfg   = err_cfg_q;
      bus.err_miss  = miss_q;
      bus.pulse_idx = idx_q;
   end

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Scoreboard bench for pulse_train_ctrl with a behavioural sigpulse responder.
module tb_pulse_train_ctrl;

   localparam int EV_EN    = 0;
   localparam int EV_DONE  = 1;
   localparam int EV_ABORT = 2;
   localparam int EV_ERR   = 3;

   typedef struct {
      int kind;
      int cyc;
      int idx;   // -1: not compared
      int miss;
      int width;
   } ev_t;

   logic io_clk = 1'b0;
   logic io_rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   ev_t  expq[$];
   int   valid_due = -1;
   bit   connected = 1'b1;
   bit   miss_sticky = 1'b0;

   pulse_train_ctrl_if bus ();

   pulse_train_ctrl dut (
      .io_clk(io_clk),
      .io_rst(io_rst),
      .bus   (bus.slave)
   );

   always #5 io_clk = ~io_clk;

   always @(posedge io_clk) cyc <= cyc + 1;

   function automatic void check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic string kname(input int k);
      case (k)
         EV_EN:    return "sp_en";
         EV_DONE:  return "done";
         EV_ABORT: return "aborted";
         default:  return "err_cfg";
      endcase
   endfunction

   task automatic handle(input int kind);
      ev_t e;
      if (expq.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_%s: got strobe at cycle %0d, required none", kname(kind), cyc);
         return;
      end
      e = expq.pop_front();
      check({"kind_", kname(kind)}, kind, e.kind);
      check({"cycle_", kname(kind)}, cyc, e.cyc);
      if (e.idx >= 0) check({"pulse_idx_", kname(kind)}, bus.pulse_idx, e.idx);
      case (kind)
         EV_EN: begin
            check("sp_width", bus.sp_width, e.width);
            check("busy_at_en", bus.busy, 1);
         end
         EV_ABORT: begin
            check("sp_dis_at_abort", bus.sp_dis, 1);
            check("err_miss_at_abort", bus.err_miss, e.miss);
         end
         EV_DONE: check("busy_at_done", bus.busy, 1);
         default: check("busy_at_err_cfg", bus.busy, 0);
      endcase
   endtask

   // Monitor: sample away from the active edge, pop and compare on every strobe
   always @(negedge io_clk) begin
      if (io_rst) begin
         valid_due = -1;
      end else begin
         if (bus.sp_en) begin
            valid_due = cyc + int'(bus.sp_width);
            handle(EV_EN);
         end
         if (bus.done) handle(EV_DONE);
         if (bus.aborted) handle(EV_ABORT);
         if (bus.err_cfg) handle(EV_ERR);
         if (bus.sp_dis) valid_due = -1;
      end
   end

   // sigpulse stand-in: pulse_valid in the last cycle of each pulse
   initial begin
      bus.sp_valid = 1'b0;
      forever begin
         @(posedge io_clk);
         #1;
         bus.sp_valid = connected && (cyc == valid_due);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge io_clk);
      #1;
   endtask

   task automatic push(input int kind, input int c, input int idx, input int miss, input int w);
      ev_t e;
      e.kind = kind; e.cyc = c; e.idx = idx; e.miss = miss; e.width = w;
      expq.push_back(e);
   endtask

   task automatic scramble_cfg();
      bus.cfg_delay  = $urandom_range(0, 7);
      bus.cfg_width  = $urandom_range(0, 7);
      bus.cfg_period = $urandom_range(0, 9);
      bus.cfg_count  = 16'($urandom_range(0, 5));
   endtask

   // mode: 0 normal, 1 stop mid-train, 2 sp_valid disconnected,
   //       3 start re-pulsed while busy, 4 start+stop in same IDLE cycle
   task automatic do_train(input int d, input int w, input int p, input int n,
                           input int mode, input int off);
      int e, f0, endc, s, abort_c, last;
      bit ok, acc;
      tick();
      e = cyc;
      check("err_miss_before_start", bus.err_miss, miss_sticky);
      ok  = (w != 0) && (n != 0) && (p > w);
      acc = ok && (mode != 4);
      connected = (mode != 2);
      bus.start = 1'b1;
      bus.stop = (mode == 4);
      bus.cfg_delay = d;
      bus.cfg_width = w;
      bus.cfg_period = p;
      bus.cfg_count = 16'(n);
      f0 = e + d + 2;
      endc = f0 + n * p;
      s = -1;
      abort_c = -1;
      if (mode != 4 && !ok) begin
         push(EV_ERR, e + 1, -1, 0, 0);
      end else if (acc) begin
         if (mode == 1 || mode == 3) s = e + 1 + ((off >= 0) ? off : $urandom_range(0, endc - e - 2));
         if (mode == 1) abort_c = s + 1;
         if (mode == 2) abort_c = f0 + p;
         last = 0;
         for (int k = 0; k < n; k++) begin
            if (abort_c >= 0 && f0 + k * p >= abort_c) break;
            push(EV_EN, f0 + k * p, k, 0, w);
            last = k;
         end
         if (abort_c >= 0) push(EV_ABORT, abort_c, last, (mode == 2) ? 1 : 0, 0);
         else push(EV_DONE, endc, n - 1, 0, 0);
      end
      tick();
      bus.start = 1'b0;
      bus.stop = 1'b0;
      scramble_cfg();
      check("busy_after_start", bus.busy, acc);
      if (acc) begin
         check("err_miss_cleared", bus.err_miss, 0);
         miss_sticky = (mode == 2);
      end
      if (s >= 0) begin
         while (cyc < s) tick();
         if (mode == 1) begin
            bus.stop = 1'b1;
         end else begin
            bus.start = 1'b1;
            bus.cfg_delay = 1;
            bus.cfg_width = 1;
            bus.cfg_period = 2;
            bus.cfg_count = 16'd1;
         end
         tick();
         bus.stop = 1'b0;
         bus.start = 1'b0;
      end
      for (int i = 0; i < 3000 && expq.size() != 0; i++) tick();
      if (expq.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL event_timeout: got %0d pending events, required 0", expq.size());
         expq.delete();
      end
      repeat (2) tick();
      check("idle_busy", bus.busy, 0);
      check("idle_sp_dis", bus.sp_dis, 0);
      connected = 1'b1;
   endtask

   task automatic reset_mid_run();
      int e;
      tick();
      e = cyc;
      bus.start = 1'b1;
      bus.cfg_delay = 1;
      bus.cfg_width = 2;
      bus.cfg_period = 6;
      bus.cfg_count = 16'd4;
      push(EV_EN, e + 3, 0, 0, 2);
      push(EV_EN, e + 9, 1, 0, 2);
      tick();
      bus.start = 1'b0;
      while (cyc < e + 11) tick();
      #2;
      io_rst = 1'b1;
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_sp_en", bus.sp_en, 0);
      check("rst_sp_dis", bus.sp_dis, 0);
      check("rst_done", bus.done, 0);
      check("rst_aborted", bus.aborted, 0);
      check("rst_err_miss", bus.err_miss, 0);
      check("rst_pulse_idx", bus.pulse_idx, 0);
      check("rst_sp_width", bus.sp_width, 0);
      check("pre_reset_events", expq.size(), 0);
      expq.delete();
      miss_sticky = 1'b0;
      repeat (2) tick();
      io_rst = 1'b0;
      repeat (3) tick();
      check("post_reset_busy", bus.busy, 0);
   endtask

   initial begin
      int w, p, n, d, mode, kind;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.cfg_delay = '0;
      bus.cfg_width = '0;
      bus.cfg_period = '0;
      bus.cfg_count = '0;
      #1;
      io_rst = 1'b1;
      #1;
      check("reset_busy", bus.busy, 0);
      check("reset_sp_en", bus.sp_en, 0);
      check("reset_sp_dis", bus.sp_dis, 0);
      check("reset_done", bus.done, 0);
      check("reset_aborted", bus.aborted, 0);
      check("reset_err_cfg", bus.err_cfg, 0);
      check("reset_err_miss", bus.err_miss, 0);
      check("reset_pulse_idx", bus.pulse_idx, 0);
      check("reset_sp_width", bus.sp_width, 0);
      repeat (2) @(posedge io_clk);
      #1;
      io_rst = 1'b0;

      do_train(3, 2, 5, 3, 0, 0);   // basic train
      do_train(0, 5, 5, 3, 0, 0);   // width == period rejected
      do_train(0, 2, 5, 0, 0, 0);   // count 0 rejected
      do_train(2, 2, 6, 4, 1, 10);  // stop mid-pulse of pulse 1
      do_train(1, 2, 4, 3, 2, 0);   // missing pulse_valid
      do_train(0, 2, 4, 2, 0, 0);   // clears err_miss; delay 0
      do_train(0, 1, 3, 2, 3, -1);  // start while busy
      do_train(0, 1, 3, 2, 4, 0);   // start+stop in IDLE
      reset_mid_run();
      do_train(1, 1, 2, 3, 0, 0);   // normal after reset, minimal period

      for (int t = 0; t < 40; t++) begin
         d = $urandom_range(0, 5);
         w = $urandom_range(1, 4);
         p = w + $urandom_range(1, 5);
         n = $urandom_range(1, 4);
         mode = $urandom_range(0, 4);
         if ($urandom_range(0, 4) == 0) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) w = 0;
            else if (kind == 1) n = 0;
            else p = $urandom_range(1, w);
         end
         do_train(d, w, p, n, mode, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
